// File: rtl/uart_pkg.sv
// Shared UART types, frame levels and baud helper for the TX/RX stages.
// UART_TX_PARITY_EN adds the even-parity state to tx_state_t.
package uart_pkg;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } tx_state_t;

  function automatic int symbol_edge_time(
    input int clock_freq,
    input int baud_rate
  );
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Symbol timer: one-cycle symbol_end strobe every SYMBOL_EDGE_TIME
// enabled cycles; held at zero while disabled. Shared with the RX side.
module uart_baud_gen #(
  parameter int SYMBOL_EDGE_TIME = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic symbol_end
);

  localparam int W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam logic [W-1:0] LAST = W'(SYMBOL_EDGE_TIME - 1);

  logic [W-1:0] r_cnt;

  assign symbol_end = enable && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      r_cnt <= '0;
    end else if (symbol_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit stage: pops a byte from the TX FIFO and sends it 8N1.
// Define UART_TX_PARITY_EN for 8E1 framing.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out,
  output logic       busy
);

  localparam int SET = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);

  generate
    if (SET < 2) begin : g_bad_baud
      $error("uart_tx_serializer: CLOCK_FREQ/BAUD_RATE must be >= 2");
    end
  endgenerate

  tx_state_t              r_state;
  logic [DATA_BITS-1:0]   r_shift;
  logic [2:0]             r_idx;
  logic                   r_tx;
  logic                   w_sym_end;
  logic                   w_baud_en;
`ifdef UART_TX_PARITY_EN
  logic                   r_parity;
`endif

  assign w_baud_en     = (r_state != TX_IDLE);
  assign data_in_ready = (r_state == TX_IDLE);
  assign busy          = w_baud_en;
  assign serial_out    = r_tx;

  uart_baud_gen #(
    .SYMBOL_EDGE_TIME(SET)
  ) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (w_baud_en),
    .symbol_end (w_sym_end)
  );

  // r_tx is loaded with the level of the symbol being entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= TX_IDLE;
      r_shift  <= '0;
      r_idx    <= '0;
      r_tx     <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        TX_IDLE: begin
          if (data_in_valid) begin
            r_shift  <= data_in;
            r_idx    <= '0;
            r_tx     <= START_LEVEL;
            r_state  <= TX_START;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^data_in;
`endif
          end
        end
        TX_START: begin
          if (w_sym_end) begin
            r_tx    <= r_shift[0];
            r_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (w_sym_end) begin
            r_shift <= r_shift >> 1;
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= TX_PARITY;
`else
              r_tx    <= STOP_LEVEL;
              r_state <= TX_STOP;
`endif
            end else begin
              r_tx <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        TX_PARITY: begin
          if (w_sym_end) begin
            r_tx    <= STOP_LEVEL;
            r_state <= TX_STOP;
          end
        end
`endif
        TX_STOP: begin
          if (w_sym_end) begin
            r_tx    <= IDLE_LEVEL;
            r_state <= TX_IDLE;
          end
        end
        default: begin
          r_tx    <= IDLE_LEVEL;
          r_state <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with a line-side receiver
// scoreboard. Honours UART_TX_PARITY_EN.
module tb_uart_tx_serializer;

  localparam int CF  = 1000;
  localparam int BR  = 100;
  localparam int SET = CF / BR;
`ifdef UART_TX_PARITY_EN
  localparam int NSYM = 11;
`else
  localparam int NSYM = 10;
`endif
  localparam int FRAME = NSYM * SET;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic       serial_out;
  logic       busy;

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .CLOCK_FREQ(CF),
    .BAUD_RATE (BR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out   (serial_out),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int hs_n = 0;
  int hs_cyc = -1;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  always @(posedge clk) begin
    if (rst_n && data_in_valid && data_in_ready) begin
      hs_n++;
      hs_cyc = cyc;
    end
  end

  function automatic logic exp_bit(input logic [7:0] b, input int s);
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
    if (NSYM == 11 && s == 9) return ^b;
    return 1'b1;
  endfunction

  // receiver: detect start, sample mid-symbol, compare to queue
  logic        rx_act = 1'b0;
  int          rx_t = 0;
  int          rx_frames = 0;
  logic [10:0] rx_b = '0;

  task automatic frame_done();
    logic [7:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check("rx_start", 32'(rx_b[0]), 32'(1'b0));
    check("rx_data", 32'(rx_b[8:1]), 32'(e));
`ifdef UART_TX_PARITY_EN
    check("rx_parity", 32'(rx_b[9]), 32'(^e));
`endif
    check("rx_stop", 32'(rx_b[NSYM-1]), 32'(1'b1));
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      if (rx_act) begin
        rx_act = 1'b0;
        exp_q.delete();
      end
    end else if (!rx_act) begin
      if (serial_out === 1'b0) begin
        rx_act = 1'b1;
        rx_t = 0;
      end
    end else begin
      rx_t++;
      if (rx_t % SET == SET / 2) begin
        rx_b[rx_t/SET] = serial_out;
        if (rx_t / SET == NSYM - 1) begin
          rx_act = 1'b0;
          rx_frames++;
          frame_done();
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, output int n);
    data_in = b;
    data_in_valid = 1'b1;
    exp_q.push_back(b);
    n = cyc;
    tick();
    check("hs_cycle", 32'(hs_cyc), 32'(n));
    check("hs_line_low", 32'(serial_out), 32'(1'b0));
  endtask

  task automatic expect_frame(input logic [7:0] b, input string tag);
    int bad_line = 0;
    int bad_ctl = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (serial_out !== exp_bit(b, i / SET)) bad_line++;
      if (data_in_ready !== 1'b0 || busy !== 1'b1) bad_ctl++;
      tick();
    end
    check({tag, "_line"}, 32'(bad_line), 32'd0);
    check({tag, "_ctl"}, 32'(bad_ctl), 32'd0);
    check({tag, "_ready_back"}, 32'(data_in_ready), 32'(1'b1));
    check({tag, "_line_idle"}, 32'(serial_out), 32'(1'b1));
  endtask

  initial begin
    int n0;
    int h;
    int bad;

    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_line", 32'(serial_out), 32'(1'b1));
    check("rst_busy", 32'(busy), 32'(1'b0));
    check("rst_ready", 32'(data_in_ready), 32'(1'b1));
    tick();

    send(8'hA5, n0);
    data_in_valid = 1'b0;
    expect_frame(8'hA5, "single");
    check("single_busy_idle", 32'(busy), 32'(1'b0));

    send(8'h00, n0);
    data_in = 8'hFF;
    exp_q.push_back(8'hFF);
    expect_frame(8'h00, "b2b0");
    tick();
    check("b2b_gap", 32'(hs_cyc - n0), 32'(FRAME + 1));
    data_in_valid = 1'b0;
    expect_frame(8'hFF, "b2b1");

    h = hs_n;
    bad = 0;
    repeat (500) begin
      data_in = 8'($urandom);
      if (serial_out !== 1'b1 || busy !== 1'b0 || data_in_ready !== 1'b1)
        bad++;
      tick();
    end
    check("empty_idle", 32'(bad), 32'd0);
    check("empty_no_hs", 32'(hs_n), 32'(h));

    send(8'h3C, n0);
    data_in_valid = 1'b0;
    repeat (34) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_line", 32'(serial_out), 32'(1'b1));
    check("midrst_busy", 32'(busy), 32'(1'b0));
    check("midrst_ready", 32'(data_in_ready), 32'(1'b1));
    send(8'h81, n0);
    data_in_valid = 1'b0;
    expect_frame(8'h81, "after_rst");

    h = hs_n;
    bad = 0;
    data_in = 8'h5A;
    data_in_valid = 1'b1;
    rst_n = 1'b0;
    exp_q.push_back(8'h5A);
    repeat (5) begin
      tick();
      if (serial_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("rsthold_idle", 32'(bad), 32'd0);
    check("rsthold_no_hs", 32'(hs_n), 32'(h));
    rst_n = 1'b1;
    n0 = cyc;
    tick();
    check("rsthold_hs_cycle", 32'(hs_cyc), 32'(n0));
    check("rsthold_hs_count", 32'(hs_n), 32'(h + 1));
    check("rsthold_line_low", 32'(serial_out), 32'(1'b0));
    data_in_valid = 1'b0;
    expect_frame(8'h5A, "rsthold");

    send(8'h07, n0);
    data_in_valid = 1'b0;
    expect_frame(8'h07, "byte07");

    repeat (3) tick();
    check("rx_frames", 32'(rx_frames), 32'd6);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Serial transmit stage that drains the transmit FIFO and drives the UART TX pin. It pops one byte with a ready/valid handshake. It shifts the byte out as an 8N1 frame (optionally 8E1) at a parameterised baud rate. It sits directly downstream of the TX FIFO, with its input connected to the FIFO's dequeue port, and has no flow control on the line side.

## Interface
- CLOCK_FREQ, 125_000_000: system clock frequency in Hz.
- BAUD_RATE, 115_200: line rate in bit/s.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- data_in  input  8  byte to send. Connects to the FIFO dequeue data and is only sampled on a handshake.
- data_in_valid  input  1  a byte is available (FIFO dequeue valid).
- data_in_ready  output  1  the block will accept a byte this cycle (FIFO dequeue ready).
- serial_out  output  1  UART TX line; idles high.
- busy  output  1  a frame is in flight (any state other than IDLE).

## Operation
- SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE, using truncating integer division. The elaboration check requires it to be at least 2.
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE
  - data_in_ready=1, busy=0, serial_out=1.
  - Handshake when data_in_valid && data_in_ready: latch data_in into the shift register, clear the baud counter, move to START.
- START: serial_out=0 for SYMBOL_EDGE_TIME cycles, then move to DATA with bit index 0.
- DATA
  - serial_out = shift[0], one bit per SYMBOL_EDGE_TIME cycles, LSB first.
  - After bit 7 completes, move to PARITY if the macro is defined, otherwise to STOP.
- STOP: serial_out=1 for SYMBOL_EDGE_TIME cycles, then return to IDLE.
- data_in_ready is combinational: it equals (state==IDLE). No byte is accepted in any other state, so data_in is ignored outside a handshake.
- Baud counter
  - Width $clog2(SYMBOL_EDGE_TIME).
  - Counts 0 to SYMBOL_EDGE_TIME-1 and produces a one-cycle symbol-end strobe at the terminal count.
  - Wraps to 0 on the strobe and is held at 0 in IDLE.
- Bit index is 3 bits and advances on the symbol-end strobe in DATA.
- data_in_valid low in IDLE: the block stays in IDLE indefinitely with the line high. This covers an empty FIFO.

## Timing
- Reset (rst_n low at a rising edge):
  - state=IDLE, serial_out=1, busy=0, data_in_ready=1 from the first cycle after reset.
  - The baud counter, bit index and shift register are cleared.
  - A handshake presented in a reset cycle is ignored and no byte is consumed. The FIFO is reset by the same net.
- Reset mid-frame aborts the frame. serial_out is 1 in the next cycle; the partial frame is not resumed.
- Handshake at cycle N: serial_out falls at N+1 (registered output). busy=1 from N+1.
- Frame length is exactly 10*SYMBOL_EDGE_TIME cycles, or 11*SYMBOL_EDGE_TIME with parity.
- Last STOP cycle is N+10*SYMBOL_EDGE_TIME. The state is IDLE in the following cycle, so data_in_ready=1 there.
- Back-to-back: if valid is held, the next handshake occurs in that first IDLE cycle. The idle gap between frames is exactly 1 cycle beyond the stop bit.
- Throughput is one byte per 10*SYMBOL_EDGE_TIME+1 cycles.

## Configuration
- UART_TX_PARITY_EN defined:
  - Adds the PARITY state after DATA.
  - serial_out = ^byte (even parity) for SYMBOL_EDGE_TIME cycles.
  - Frame becomes 11 symbols.
- UART_TX_PARITY_EN undefined: 8N1. PARITY state and parity logic are absent; DATA goes straight to STOP.

## Structure
- Package uart_pkg holds:
  - The state enum type (tx_state_t).
  - The frame constants: DATA_BITS=8, START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1.
  - A function computing SYMBOL_EDGE_TIME from CLOCK_FREQ and BAUD_RATE.
- One sub-module, uart_baud_gen:
  - Inputs: clk, rst_n, enable.
  - Output: a one-cycle symbol_end strobe.
  - Parameter: SYMBOL_EDGE_TIME.
  - Reused later by the RX side.

## Test plan
Common setting: CLOCK_FREQ=1000, BAUD_RATE=100, so SYMBOL_EDGE_TIME=10.
- Single byte: drive 0xA5 with valid for 1 cycle at cycle N.
  - serial_out levels per 10-cycle symbol: 0, 1,0,1,0,0,1,0,1, 1.
  - data_in_ready=0 from N+1 to N+100, and 1 at N+101.
- Back-to-back: hold valid with 0x00 then 0xFF.
  - The second handshake lands exactly 101 cycles after the first.
  - Line pattern: 0 for 90 cycles, 1 for 10 cycles, 1 for 1 cycle, 0 for 10 cycles, 1 for 90 cycles.
- Empty FIFO: valid=0 for 500 cycles.
  - serial_out stays 1, busy=0, data_in_ready=1, no handshake occurs.
- Mid-frame reset: rst_n low for 1 cycle at N+35 of a 0x3C frame.
  - serial_out=1 at N+36, busy=0, data_in_ready=1.
  - A new byte 0x81 then produces a full, correct frame.
- Reset ignores handshake: valid=1 during rst_n=0 for 5 cycles.
  - No frame starts until the first cycle after rst_n rises.
- With UART_TX_PARITY_EN defined: send 0x07 (three ones).
  - Parity symbol is 1, the frame is 110 cycles, and ready returns at N+111.
